// File: rtl/ysyx_23060061_axil_master_if.sv
// AXI-Lite bus bundle between the CPU-side master bridge and a memory-mapped slave.
interface ysyx_23060061_axil_master_if;
    // Read address / read data
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    // Write address / write data / write response
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060061_axil_master.sv
// CPU load/store request to AXI-Lite bridge. One outstanding transaction at a time;
// sub-word accesses are lane-steered on the bus and right-aligned on the CPU side.
module ysyx_23060061_axil_master #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    // CPU request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    // CPU response
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // AXI-Lite bus
    ysyx_23060061_axil_master_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrXfer,
        StWrResp,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        misaligned;
    logic        bad_req;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wlane;
    logic [31:0] rd_shift;
    logic [31:0] rd_lane;
    logic        ar_fire;
    logic        aw_fire;
    logic        w_fire;

    // Classify the incoming request: illegal size always errors, misalignment only if checked.
    always_comb begin
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        bad_req    = (req_size == 2'b11) || (ALIGN_CHECK && misaligned);
    end

    // Steer write data into the addressed byte lanes and build the strobe.
    always_comb begin
        unique case (req_size)
            2'b00: begin
                req_wstrb = 4'b0001 << req_addr[1:0];
                req_wlane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_wstrb = 4'b0011 << req_addr[1:0];
                req_wlane = {2{req_wdata[15:0]}};
            end
            default: begin
                req_wstrb = 4'b1111;
                req_wlane = req_wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the read beat and extend it.
    always_comb begin
        rd_shift = bus.rdata >> {addr_q[1:0], 3'b000};
        unique case (size_q)
            2'b00:   rd_lane = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_lane = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_lane = bus.rdata;
        endcase
    end

    assign ar_fire = bus.arvalid && bus.arready;
    assign aw_fire = bus.awvalid && bus.awready;
    assign w_fire  = bus.wvalid && bus.wready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; each bus handshake is only looked at in its own state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (bad_req) begin
                        state_d = StResp;
                    end else if (req_wen) begin
                        state_d = StWrXfer;
                    end else begin
                        state_d = StRdAddr;
                    end
                end
            end
            StRdAddr: if (ar_fire) state_d = StRdData;
            StRdData: if (bus.rvalid) state_d = StResp;
            StWrXfer: begin
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: if (bus.bvalid) state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from registered state only, so no input-to-output paths exist.
    always_comb begin
        req_ready   = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        resp_valid  = 1'b0;
        unique case (state_q)
            StIdle:   req_ready = 1'b1;
            StRdAddr: bus.arvalid = 1'b1;
            StRdData: bus.rready = 1'b1;
            StWrXfer: begin
                bus.awvalid = !aw_done_q;
                bus.wvalid  = !w_done_q;
            end
            StWrResp: bus.bready = 1'b1;
            StResp:   resp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign bus.araddr = {addr_q[31:2], 2'b00};
    assign bus.awaddr = {addr_q[31:2], 2'b00};
    assign bus.wdata  = wdata_q;
    assign bus.wstrb  = wstrb_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Next values for the request capture, per-channel done flags and response latch.
    always_comb begin
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d       = req_addr;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    wdata_d      = req_wlane;
                    wstrb_d      = req_wstrb;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = bad_req;
                end
            end
            StRdData: begin
                if (bus.rvalid) begin
                    resp_rdata_d = rd_lane;
                    resp_err_d   = (bus.rresp != 2'b00);
                end
            end
            StWrXfer: begin
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
            end
            StWrResp: begin
                if (bus.bvalid) begin
                    resp_rdata_d = 32'h0;
                    resp_err_d   = (bus.bresp != 2'b00);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'b0000;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_axil_master.sv
// Bench for the AXI-Lite master bridge: a behavioural slave with programmable channel
// latencies, and a response scoreboard filled as requests are driven.
module tb_ysyx_23060061_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    ysyx_23060061_axil_master_if bus ();

    ysyx_23060061_axil_master #(
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Slave configuration and observation log.
    int          ar_lat = 0, aw_lat = 0, w_lat = 0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    bit          r_stall = 1'b0, stray = 1'b0;
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    bit          r_pend = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, r_hs = 0;
    int          ar_seen = 0, aw_seen = 0, w_seen = 0;
    int          viol = 0;
    logic [31:0] got_araddr = 32'h0, got_awaddr = 32'h0, got_wdata = 32'h0;
    logic [3:0]  got_wstrb = 4'h0;
    logic        prev_arvalid = 1'b0;
    logic [31:0] prev_araddr = 32'h0;

    // Behavioural AXI-Lite slave, updated on the falling edge.
    initial begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0;
                bus.wready = 1'b0; bus.bvalid = 1'b0;
                r_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; prev_arvalid = 1'b0;
            end else begin
                if (bus.arvalid) begin
                    ar_seen++;
                    if (prev_arvalid && bus.araddr !== prev_araddr) viol++;
                    if (ar_wait >= ar_lat) begin
                        bus.arready = 1'b1; ar_hs++; got_araddr = bus.araddr;
                        r_pend = 1'b1; ar_wait = 0;
                    end else begin
                        bus.arready = 1'b0; ar_wait++;
                    end
                end else begin
                    bus.arready = 1'b0; ar_wait = 0;
                end
                prev_arvalid = bus.arvalid && !bus.arready;
                prev_araddr  = bus.araddr;

                if (stray) begin
                    bus.rvalid = 1'b1; bus.rdata = 32'h5A5A_5A5A; bus.rresp = 2'b11;
                    bus.bvalid = 1'b1; bus.bresp = 2'b11;
                end else begin
                    if (bus.rready && r_pend && !r_stall) begin
                        bus.rvalid = 1'b1; bus.rdata = s_rdata; bus.rresp = s_rresp;
                        r_pend = 1'b0; r_hs++;
                    end else begin
                        bus.rvalid = 1'b0;
                    end
                    if (bus.bready && aw_pend && w_pend) begin
                        bus.bvalid = 1'b1; bus.bresp = s_bresp;
                        aw_pend = 1'b0; w_pend = 1'b0; b_hs++;
                    end else begin
                        bus.bvalid = 1'b0;
                    end
                end

                if (bus.awvalid) begin
                    aw_seen++;
                    if (aw_pend) viol++;
                    if (aw_wait >= aw_lat) begin
                        bus.awready = 1'b1; aw_hs++; got_awaddr = bus.awaddr;
                        aw_pend = 1'b1; aw_wait = 0;
                    end else begin
                        bus.awready = 1'b0; aw_wait++;
                    end
                end else begin
                    bus.awready = 1'b0; aw_wait = 0;
                end

                if (bus.wvalid) begin
                    w_seen++;
                    if (w_pend) viol++;
                    if (w_wait >= w_lat) begin
                        bus.wready = 1'b1; w_hs++; got_wdata = bus.wdata;
                        got_wstrb = bus.wstrb; w_pend = 1'b1; w_wait = 0;
                    end else begin
                        bus.wready = 1'b0; w_wait++;
                    end
                end else begin
                    bus.wready = 1'b0; w_wait = 0;
                end
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Issue one request, collect its response, compare against the scoreboard head.
    task automatic do_req(input string name, input logic wen, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat, input int hold);
        exp_t        e;
        int          n;
        int          lat;
        logic [31:0] snap_d;
        logic        snap_e;
        e.err = exp_err;
        e.rdata = exp_rd;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
            req_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: resp_valid=%b required 1", name, resp_valid);
            void'(sb.pop_front());
            return;
        end
        if (exp_lat > 0) begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
            end
        end
        snap_d = resp_rdata;
        snap_e = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== snap_d || resp_err !== snap_e ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         name, resp_valid, resp_rdata, resp_err, req_ready, snap_d, snap_e);
            end
        end
        resp_ready = 1'b1;
        e = sb.pop_front();
        checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s resp: err=%b rdata=%h required err=%b rdata=%h",
                     name, resp_err, resp_rdata, e.err, e.rdata);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b required 0 1",
                     name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
             resp_valid, resp_err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/ar/aw/w/r/b/resp/err=%b required 10000000",
                     {req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                      bus.bready, resp_valid, resp_err});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 00000000", resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_read();
        int r0;
        r0 = r_hs;
        ar_lat = 0; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        do_req("word_read", 1'b0, 32'h8000_0004, 2'b10, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 0);
        checks++;
        if (got_araddr !== 32'h8000_0004 || r_hs !== r0 + 1) begin
            errors++;
            $display("FAIL word_read_bus: araddr=%h rbeats=%0d required 80000004 1",
                     got_araddr, r_hs - r0);
        end
    endtask

    task automatic test_byte_read();
        s_rdata = 32'h80FF_0000;
        do_req("byte_read_s", 1'b0, 32'h8000_0003, 2'b00, 1'b1, 32'h0, 1'b0, 32'hFFFF_FF80, 3, 0);
        do_req("byte_read_u", 1'b0, 32'h8000_0003, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0000_0080, 3, 0);
        checks++;
        if (got_araddr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL byte_read_addr: araddr=%h required 80000000", got_araddr);
        end
    endtask

    task automatic test_half_read();
        ar_lat = 3; s_rdata = 32'h8001_1234;
        do_req("half_read", 1'b0, 32'h8000_0002, 2'b01, 1'b1, 32'h0, 1'b0, 32'hFFFF_8001, 6, 0);
        ar_lat = 0;
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL half_read_stable: violations=%0d required 0", viol);
        end
    endtask

    task automatic test_half_write();
        int b0;
        b0 = b_hs;
        aw_lat = 0; w_lat = 5; s_bresp = 2'b00;
        do_req("half_write", 1'b1, 32'h8000_0002, 2'b01, 1'b0, 32'h0000_1234, 1'b0, 32'h0, 8, 0);
        w_lat = 0;
        checks++;
        if (got_awaddr !== 32'h8000_0000 || got_wstrb !== 4'b1100 ||
            got_wdata !== 32'h1234_1234 || b_hs !== b0 + 1 || viol !== 0) begin
            errors++;
            $display("FAIL half_write_bus: awaddr=%h wstrb=%b wdata=%h b=%0d viol=%0d required 80000000 1100 12341234 1 0",
                     got_awaddr, got_wstrb, got_wdata, b_hs - b0, viol);
        end
    endtask

    task automatic test_byte_write();
        aw_lat = 3; w_lat = 0;
        do_req("byte_write", 1'b1, 32'h8000_0011, 2'b00, 1'b0, 32'hFFFF_FFA5, 1'b0, 32'h0, 0, 0);
        aw_lat = 0;
        checks++;
        if (got_awaddr !== 32'h8000_0010 || got_wstrb !== 4'b0010 ||
            got_wdata !== 32'hA5A5_A5A5 || viol !== 0) begin
            errors++;
            $display("FAIL byte_write_bus: awaddr=%h wstrb=%b wdata=%h viol=%0d required 80000010 0010 a5a5a5a5 0",
                     got_awaddr, got_wstrb, got_wdata, viol);
        end
    endtask

    task automatic test_misaligned();
        int a0, w0, x0;
        a0 = ar_seen; w0 = aw_seen; x0 = w_seen;
        do_req("mis_word", 1'b0, 32'h8000_0001, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0);
        do_req("mis_half", 1'b1, 32'h8000_0003, 2'b01, 1'b0, 32'hFFFF, 1'b1, 32'h0, 1, 0);
        do_req("bad_size", 1'b0, 32'h8000_0000, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0);
        checks++;
        if (ar_seen !== a0 || aw_seen !== w0 || w_seen !== x0) begin
            errors++;
            $display("FAIL misaligned_bus: ar/aw/w valid cycles=%0d/%0d/%0d required 0/0/0",
                     ar_seen - a0, aw_seen - w0, w_seen - x0);
        end
    endtask

    task automatic test_bus_errors();
        s_bresp = 2'b10;
        do_req("write_err", 1'b1, 32'h8000_0008, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0, 3, 4);
        s_bresp = 2'b00;
        s_rresp = 2'b10; s_rdata = 32'h1122_3344;
        do_req("read_err", 1'b0, 32'h8000_000C, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1122_3344, 3, 0);
        s_rresp = 2'b00;
    endtask

    task automatic test_stray();
        int r0;
        r0 = r_hs;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bus.rready !== 1'b0) begin
            errors++;
            $display("FAIL stray: resp_valid=%b req_ready=%b rready=%b required 0 1 0",
                     resp_valid, req_ready, bus.rready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        r_stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020; req_size = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (bus.rready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reach: rready=%b required 1", bus.rready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rready !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            bus.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rready=%b req_ready=%b resp_valid=%b arvalid=%b required 0 1 0 0",
                     bus.rready, req_ready, resp_valid, bus.arvalid);
        end
        rst = 1'b0;
        r_stall = 1'b0;
        r_pend = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_mid_noresp: resp_valid cycles=%0d required 0", n);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  size;
        logic [1:0]  off;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] lanes;
        logic        wen;
        logic        sgn;
        for (int i = 0; i < 12; i++) begin
            size = 2'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            if (size == 2'b01) off[0] = 1'b0;
            if (size == 2'b10) off = 2'b00;
            addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFC) | {30'h0, off};
            wd = $urandom;
            wen = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            ar_lat = $urandom_range(0, 3); aw_lat = $urandom_range(0, 3);
            w_lat = $urandom_range(0, 3);
            s_rdata = $urandom;
            if (wen) begin
                do_req("b2b_write", 1'b1, addr, size, sgn, wd, 1'b0, 32'h0, 0, 0);
                case (size)
                    2'b00: begin
                        strb = 4'b0001 << off; lanes = {4{wd[7:0]}};
                    end
                    2'b01: begin
                        strb = off[1] ? 4'b1100 : 4'b0011; lanes = {2{wd[15:0]}};
                    end
                    default: begin
                        strb = 4'b1111; lanes = wd;
                    end
                endcase
                checks++;
                if (got_awaddr !== {addr[31:2], 2'b00} || got_wstrb !== strb ||
                    got_wdata !== lanes) begin
                    errors++;
                    $display("FAIL b2b_write_bus: awaddr=%h wstrb=%b wdata=%h required %h %b %h",
                             got_awaddr, got_wstrb, got_wdata, {addr[31:2], 2'b00}, strb, lanes);
                end
            end else begin
                do_req("b2b_read", 1'b0, addr, size, sgn, 32'h0, 1'b0,
                       model_read(s_rdata, off, size, sgn), 0, 0);
                checks++;
                if (got_araddr !== {addr[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL b2b_read_addr: araddr=%h required %h",
                             got_araddr, {addr[31:2], 2'b00});
                end
            end
        end
        ar_lat = 0; aw_lat = 0; w_lat = 0;
        checks++;
        if (sb.size() !== 0 || viol !== 0) begin
            errors++;
            $display("FAIL b2b_final: pending=%0d violations=%0d required 0 0", sb.size(), viol);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        req_signed = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
        test_reset();
        test_word_read();
        test_byte_read();
        test_half_read();
        test_half_write();
        test_byte_write();
        test_misaligned();
        test_bus_errors();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/ysyx_23060061_axil_master.md
YSYX_23060061_AXIL_MASTER -- requirements
Module: ysyx_23060061_AXIL_MASTER

Interface
REQ-001 Parameter: ALIGN_CHECK, 1, 1 = misaligned requests return an error and issue no bus transaction; 0 = address passed through unchecked.
REQ-002 clk  input  1  single clock; all logic samples on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU request valid.
REQ-005 req_ready  output  1  request accepted when high with req_valid.
REQ-006 req_wen  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 req_signed  input  1  read result is sign-extended when set.
REQ-010 req_wdata  input  32  write data, right-aligned (LSB = bit 0).
REQ-011 resp_valid / resp_ready  output / input  1 / 1  response handshake.
REQ-012 resp_rdata  output  32  read data, right-aligned and extended; 0 for writes.
REQ-013 resp_err  output  1  bus error, misalignment, or illegal size.
REQ-014 AXI-Lite AR channel: araddr out 32, arvalid out 1, arready in 1.
REQ-015 AXI-Lite R channel: rdata in 32, rresp in 2, rvalid in 1, rready out 1.
REQ-016 AXI-Lite AW channel: awaddr out 32, awvalid out 1, awready in 1.
REQ-017 AXI-Lite W channel: wdata out 32, wstrb out 4, wvalid out 1, wready in 1.
REQ-018 AXI-Lite B channel: bresp in 2, bvalid in 1, bready out 1.

Function
REQ-019 The block SHALL implement the states IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP and RESP.
REQ-020 IDLE: req_ready=1 and all bus valid/ready outputs are 0; the other states hold req_ready=0, so there is one outstanding transaction.
REQ-021 Request accept in IDLE, read: capture address, size and sign into registers, then go to RD_ADDR.
REQ-022 Request accept in IDLE, write: capture address, data and strobe into registers, then go to WR_XFER.
REQ-023 Request accept in IDLE, misaligned (half with addr[0]=1, word with addr[1:0]!=0) and ALIGN_CHECK=1: go directly to RESP with resp_err=1; no bus valid is asserted.
REQ-024 Request accept in IDLE, req_size=11: same behaviour as REQ-023, independent of ALIGN_CHECK.
REQ-025 araddr and awaddr SHALL be {addr[31:2],2'b00}.
REQ-026 wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-027 wdata SHALL be the request data replicated into the selected lanes (byte replicated x4, half replicated x2).
REQ-028 RD_ADDR: arvalid=1 on the cycle after accept; arvalid and araddr SHALL stay stable until arready; on arvalid&&arready go to RD_DATA.
REQ-029 RD_DATA: rready=1; on rvalid, latch the lane selected by addr[1:0] and size, zero- or sign-extended, plus resp_err=(rresp!=0), then go to RESP.
REQ-030 WR_XFER: awvalid=1 and wvalid=1 together; each channel keeps its own done flag and deasserts its valid after its handshake; both handshakes may occur in the same cycle or in either order; go to WR_RESP once both are done.
REQ-031 WR_RESP: bready=1; on bvalid, set resp_err=(bresp!=0) and resp_rdata=0, then go to RESP.
REQ-032 RESP: resp_valid=1 with stable resp_rdata and resp_err until resp_ready; on the handshake, go to IDLE; a new request can be accepted the cycle after.
REQ-033 Bus handshakes SHALL be taken only in their own states; rvalid or bvalid arriving in another state is ignored.
REQ-034 Minimum latency, zero-wait slave: read and write each produce resp_valid 3 cycles after the request accept edge.
REQ-035 There SHALL be no timeout; the block waits indefinitely on any channel.

Reset
REQ-036 While rst=1 at a rising edge: state=IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid and resp_err=0; resp_rdata=0; done flags cleared.
REQ-037 Reset mid-transaction SHALL drop all valids on the next edge and discard the in-flight request; no response is produced for it.

Verification
REQ-038 Word read at 0x8000_0004, slave returns 0xDEAD_BEEF with rresp=0 -> araddr=0x8000_0004, resp_rdata=0xDEAD_BEEF, resp_err=0, resp_valid 3 cycles after accept.
REQ-039 Signed byte read at 0x8000_0003, slave word 0x80FF_0000 -> resp_rdata=0xFFFF_FF80; same read unsigned -> 0x0000_0080.
REQ-040 Half write 0x1234 at 0x8000_0002, slave awready 5 cycles before wready -> awaddr=0x8000_0000, wstrb=1100, wdata=0x1234_1234, single bready handshake, resp_err=0.
REQ-041 Word read at 0x8000_0001 with ALIGN_CHECK=1 -> arvalid never asserted, resp_valid with resp_err=1 on the cycle after accept.
REQ-042 Write with bresp=2'b10 and resp_ready held low 4 cycles -> resp_valid and resp_err=1 held stable for 4 cycles, req_ready=0 until the handshake.
REQ-043 rst asserted in RD_DATA before rvalid -> next edge: rready=0, state IDLE, req_ready=1, no resp_valid.
